// File: rtl/alu_writeback_stage.sv
// Two-entry in-order writeback buffer between the ALU and the register file.
// Commits the retiring entry's {Z,N,C,V} into the status register when it is flagged to do so.
module alu_writeback_stage #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned REG_ADDR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     alu_out,
    input  logic                      signed_overflow,
    input  logic                      carry_flag,
    input  logic [REG_ADDR_WIDTH-1:0] dest_reg,
    input  logic                      reg_we,
    input  logic                      flags_we,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic [REG_ADDR_WIDTH-1:0] wb_dest,
    output logic                      wb_we,
    output logic [3:0]                status
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     data;
        logic [REG_ADDR_WIDTH-1:0] dest;
        logic                      reg_we;
        logic                      flags_we;
        logic [3:0]                flags;
    } entry_t;

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    entry_t new_entry;
    logic   in_ready_q, out_valid_q, wb_we_q;
    logic   [3:0] status_q, status_d;
    logic   accept, retire;

    // Flush suppresses both handshakes so nothing moves on that edge.
    assign accept = in_valid && in_ready_q && !flush;
    assign retire = out_valid_q && out_ready && !flush;

    always_comb begin
        new_entry.data     = alu_out;
        new_entry.dest     = dest_reg;
        new_entry.reg_we   = reg_we;
        new_entry.flags_we = flags_we;
        new_entry.flags    = {(alu_out == '0), alu_out[DATA_WIDTH-1], carry_flag, signed_overflow};
    end

    // Next-state and buffer movement; the head always sits in head_q.
    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        status_d = status_q;
        if (retire && head_q.flags_we) begin
            status_d = head_q.flags;
        end
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        head_d  = new_entry;
                    end
                end
                ONE: begin
                    if (accept && retire) begin
                        head_d = new_entry;
                    end else if (accept) begin
                        state_d = FULL;
                        tail_d  = new_entry;
                    end else if (retire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (retire) begin
                        state_d = ONE;
                        head_d  = tail_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State, payload and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            status_q    <= 4'b0000;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            wb_we_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            status_q    <= status_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
            wb_we_q     <= (state_d != EMPTY) && head_d.reg_we;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_data   = head_q.data;
    assign wb_dest   = head_q.dest;
    assign status    = status_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage with hand-computed expectations.
module tb_alu_writeback_stage;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready;
    logic [DW-1:0] alu_out;
    logic          signed_overflow, carry_flag;
    logic [AW-1:0] dest_reg;
    logic          reg_we, flags_we;
    logic          out_valid, out_ready;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] wb_dest;
    logic          wb_we;
    logic [3:0]    status;

    int n_checks = 0;
    int n_fails  = 0;

    alu_writeback_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .signed_overflow(signed_overflow), .carry_flag(carry_flag),
        .dest_reg(dest_reg), .reg_we(reg_we), .flags_we(flags_we),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .wb_dest(wb_dest), .wb_we(wb_we), .status(status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic c, input logic ov,
                         input logic [2:0] dst, input logic rwe, input logic fwe);
        in_valid = v; alu_out = d; carry_flag = c; signed_overflow = ov;
        dest_reg = dst; reg_we = rwe; flags_we = fwe;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        step(); step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_wb_we",     32'(wb_we),     32'd0);
        check("rst_status",    32'(status),    32'd0);
        check("rst_wb_data",   32'(wb_data),   32'd0);
        check("rst_wb_dest",   32'(wb_dest),   32'd0);
        rst = 1'b0;

        // Zero result with carry commits Z and C.
        out_ready = 1'b1;
        drive(1'b1, 8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        check("zero_out_valid", 32'(out_valid), 32'd1);
        check("zero_wb_data",   32'(wb_data),   32'h00);
        check("zero_wb_dest",   32'(wb_dest),   32'd3);
        check("zero_wb_we",     32'(wb_we),     32'd1);
        check("zero_status_pre", 32'(status),   32'd0);
        step();
        check("zero_retired",   32'(out_valid), 32'd0);
        check("zero_status",    32'(status),    32'b1010);

        // Backpressure: third entry must be refused.
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
        step();
        check("bp1_in_ready", 32'(in_ready), 32'd1);
        check("bp1_wb_data",  32'(wb_data),  32'h11);
        drive(1'b1, 8'h22, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
        step();
        check("bp2_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 8'h33, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
        step();
        check("bp3_in_ready", 32'(in_ready), 32'd0);
        check("bp3_stable",   32'(wb_data),  32'h11);
        check("bp3_dest",     32'(wb_dest),  32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        check("rel1_wb_data",   32'(wb_data),   32'h22);
        check("rel1_wb_dest",   32'(wb_dest),   32'd2);
        check("rel1_in_ready",  32'(in_ready),  32'd1);
        check("rel1_out_valid", 32'(out_valid), 32'd1);
        step();
        check("rel2_out_valid", 32'(out_valid), 32'd0);
        check("rel2_status",    32'(status),    32'b1010);

        // Simultaneous accept and retire while holding one entry.
        out_ready = 1'b0;
        drive(1'b1, 8'h05, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
        step();
        check("one_wb_data", 32'(wb_data), 32'h05);
        drive(1'b1, 8'h80, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
        out_ready = 1'b1;
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        check("sim_out_valid", 32'(out_valid), 32'd1);
        check("sim_in_ready",  32'(in_ready),  32'd1);
        check("sim_wb_data",   32'(wb_data),   32'h80);
        check("sim_status",    32'(status),    32'b0000);
        step();
        check("neg_out_valid", 32'(out_valid), 32'd0);
        check("neg_status",    32'(status),    32'b0100);

        // Register write without flag update leaves status alone.
        out_ready = 1'b0;
        drive(1'b1, 8'h7F, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        check("nf_wb_we",   32'(wb_we),   32'd1);
        check("nf_wb_data", 32'(wb_data), 32'h7F);
        check("nf_wb_dest", 32'(wb_dest), 32'd5);
        out_ready = 1'b1;
        step();
        check("nf_out_valid", 32'(out_valid), 32'd0);
        check("nf_wb_we_off", 32'(wb_we),     32'd0);
        check("nf_status",    32'(status),    32'b0100);

        // Flush from FULL with both handshakes asserted.
        out_ready = 1'b0;
        drive(1'b1, 8'hA1, 1'b0, 1'b0, 3'd6, 1'b0, 1'b1);
        step();
        check("fl_wb_we_noreg", 32'(wb_we), 32'd0);
        drive(1'b1, 8'hA2, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1);
        step();
        check("fl_full", 32'(in_ready), 32'd0);
        drive(1'b1, 8'hA3, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_in_ready",  32'(in_ready),  32'd1);
        check("fl_wb_we",     32'(wb_we),     32'd0);
        check("fl_status",    32'(status),    32'b0100);
        step();
        check("fl_empty_hold", 32'(out_valid), 32'd0);
        check("fl_status2",    32'(status),    32'b0100);

        // Reset beats flush from FULL.
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1);
        step();
        drive(1'b1, 8'h02, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1);
        step();
        check("rf_full", 32'(in_ready), 32'd0);
        rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        check("rf_out_valid", 32'(out_valid), 32'd0);
        check("rf_status",    32'(status),    32'b0000);
        check("rf_in_ready",  32'(in_ready),  32'd1);
        check("rf_wb_data",   32'(wb_data),   32'd0);
        step();
        check("rf_status2",   32'(status),    32'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
ALU_WRITEBACK_STAGE -- requirements
Module: alu_writeback_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning ALU result width.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 3, meaning destination register index width.
REQ-003 SHALL have one clock and a reset that is synchronous and active-high: clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-006 SHALL have port in_valid  input  1  upstream ALU result valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept an entry.
REQ-008 SHALL have port alu_out  input  DATA_WIDTH  ALU result.
REQ-009 SHALL have port signed_overflow  input  1  ALU signed overflow.
REQ-010 SHALL have port carry_flag  input  1  ALU carry.
REQ-011 SHALL have port dest_reg  input  REG_ADDR_WIDTH  writeback register index.
REQ-012 SHALL have port reg_we  input  1  entry writes the register file.
REQ-013 SHALL have port flags_we  input  1  entry updates status flags.
REQ-014 SHALL have port out_valid  output  1  head entry valid.
REQ-015 SHALL have port out_ready  input  1  downstream register file accepts.
REQ-016 SHALL have port wb_data  output  DATA_WIDTH  head entry result.
REQ-017 SHALL have port wb_dest  output  REG_ADDR_WIDTH  head entry index.
REQ-018 SHALL have port wb_we  output  1  out_valid AND head reg_we.
REQ-019 SHALL have port status  output  4  committed flags {Z,N,C,V}, bit3=Z.

Function
REQ-020 SHALL accept an entry when in_valid && in_ready at a rising edge; SHALL retire the head when out_valid && out_ready.
REQ-021 SHALL buffer up to 2 entries in order, state machine EMPTY/ONE/FULL.
REQ-022 SHALL transition EMPTY->ONE on accept; ONE->FULL on accept without retire; ONE->EMPTY on retire without accept; FULL->ONE on retire; ONE stays ONE on simultaneous accept+retire.
REQ-023 SHALL drive in_ready=1 in EMPTY and ONE, 0 in FULL, from registered state only (no combinational path from out_ready).
REQ-024 SHALL drive out_valid=1 in ONE and FULL, 0 in EMPTY.
REQ-025 SHALL capture per entry Z=(alu_out==0), N=alu_out[DATA_WIDTH-1], C=carry_flag, V=signed_overflow, plus dest_reg, reg_we, flags_we.
REQ-026 SHALL present head fields on wb_data/wb_dest with zero combinational latency from state; minimum in->out latency 1 cycle.
REQ-027 SHALL update status to head's {Z,N,C,V} on the cycle after retire only when head flags_we=1; otherwise status holds.
REQ-028 SHALL ignore in_valid when in_ready=0 (no overwrite, no drop of stored entries).
REQ-029 SHALL on flush=1 go to EMPTY next cycle, suppress any accept or retire that cycle, and leave status unchanged.
REQ-030 SHALL give rst priority over flush and all handshakes.
REQ-031 SHALL keep wb_data/wb_dest stable while out_valid=1 and out_ready=0.

Reset
REQ-032 SHALL on rst=1 set state EMPTY, out_valid=0, in_ready=1 the following cycle, wb_we=0, status=4'b0000, wb_data=0, wb_dest=0.
REQ-033 SHALL discard both buffered entries when rst asserts mid-operation, with no status update from them.

Verification
REQ-034 Accept alu_out=0x00,C=1,V=0,flags_we=1, out_ready=1 -> out_valid next cycle, wb_data=0x00, then status=4'b1010.
REQ-035 out_ready=0, three back-to-back accepts 0x11,0x22,0x33 -> in_ready=0 after second, 0x33 not taken; release -> retires 0x11 then 0x22 in order.
REQ-036 State ONE, in_valid=1 and out_ready=1 same cycle with 0x80 -> stays ONE, next head 0x80, N=1 committed if flags_we=1.
REQ-037 Entry alu_out=0x7F, V=1, flags_we=0, reg_we=1 retires -> wb_we=1 at retire, status unchanged from prior value.
REQ-038 FULL, flush=1 with in_valid=1 and out_ready=1 -> EMPTY next cycle, no retire, status unchanged, in_ready=1.
REQ-039 FULL, rst=1 with flush=1 -> out_valid=0, status=4'b0000 next cycle.
